// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline memory stage between EX/MEM and MEM/WB.
//   - Resolves the branch decision combinationally (PCSrc).
//   - Issues byte/half/word loads and stores over a req/ready data-memory
//     handshake, stalling upstream while an access is in flight.
//   - Registers the result into the MEM/WB pipeline register.
// Ports:
//   Clk, Rst_n            clock (rising edge), async active-low reset
//   In_*                  EX/MEM register fields (data, control, ALU flags)
//   PCSrc, Stall          combinational branch-taken / upstream hold
//   Mem_*                 data-memory request side (Req, WE, Addr, ByteEn,
//                         WData out; Ready, RData in)
//   Out_*                 MEM/WB register fields
// Build option: MEM_ALIGN_CHECK_EN enables misaligned-access detection
//   (Out_Misalign). When undefined, word accesses ignore addr[1:0], half
//   accesses ignore addr[0], and Out_Misalign stays 0.
// States:
//   ST_IDLE | no access outstanding; pass-through or issue a memop
//   ST_WAIT | request held on the memory port until Mem_Ready
module mem_access_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_Valid,
  input  logic [DATA_W-1:0] In_ALUResult,
  input  logic [DATA_W-1:0] In_StoreData,
  input  logic [4:0]        In_RegDstAddress,
  input  logic              In_RegWrite,
  input  logic              In_MemWrite,
  input  logic              In_MemRead,
  input  logic              In_MemToReg,
  input  logic              In_Branch,
  input  logic [1:0]        In_BitSel,
  input  logic [2:0]        In_BranchLogicOp,
  input  logic              In_Zero,
  input  logic              In_SignBit,
  output logic              PCSrc,
  output logic              Stall,
  output logic              Mem_Req,
  output logic              Mem_WE,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [3:0]        Mem_ByteEn,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic              Mem_Ready,
  input  logic [DATA_W-1:0] Mem_RData,
  output logic              Out_Valid,
  output logic              Out_RegWrite,
  output logic              Out_MemToReg,
  output logic [DATA_W-1:0] Out_ReadData,
  output logic [DATA_W-1:0] Out_ALUResult,
  output logic [4:0]        Out_RegDstAddress,
  output logic              Out_Misalign
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t              state_q, state_d;
  logic                req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                valid_q, valid_d, rw_q, rw_d, m2r_q, m2r_d, mis_q, mis_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d, alu_q, alu_d;
  logic [4:0]          rd_q, rd_d;

  logic [1:0]          a;
  logic                is_half, is_byte, memop, misalign;
  logic                cond;
  logic [3:0]          be_c;
  logic [DATA_W-1:0]   wdata_c, load_c;
  logic [15:0]         half_sel;
  logic [7:0]          byte_sel;

  // Branch condition
  always_comb begin
    case (In_BranchLogicOp)
      3'b000:  cond = In_Zero;
      3'b001:  cond = !In_Zero;
      3'b010:  cond = !In_SignBit;
      3'b011:  cond = !In_SignBit && !In_Zero;
      3'b100:  cond = In_SignBit || In_Zero;
      3'b101:  cond = In_SignBit;
      default: cond = 1'b0;
    endcase
  end
  assign PCSrc = In_Valid & In_Branch & cond;

  // Lane decode, store replication and load extraction
  always_comb begin
    a       = In_ALUResult[1:0];
    is_half = (In_BitSel == 2'b01);
    is_byte = (In_BitSel == 2'b10);
    memop   = In_Valid & (In_MemRead | In_MemWrite);
`ifdef MEM_ALIGN_CHECK_EN
    misalign = memop & ((!is_half && !is_byte && (a != 2'b00)) || (is_half && a[0]));
`else
    misalign = 1'b0;
`endif
    half_sel = a[1] ? Mem_RData[31:16] : Mem_RData[15:0];
    case (a)
      2'b00:   byte_sel = Mem_RData[7:0];
      2'b01:   byte_sel = Mem_RData[15:8];
      2'b10:   byte_sel = Mem_RData[23:16];
      default: byte_sel = Mem_RData[31:24];
    endcase
    if (is_half) begin
      be_c    = a[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{In_StoreData[15:0]}};
      load_c  = {{16{half_sel[15]}}, half_sel};
    end else if (is_byte) begin
      be_c    = 4'b0001 << a;
      wdata_c = {4{In_StoreData[7:0]}};
      load_c  = {{24{byte_sel[7]}}, byte_sel};
    end else begin
      be_c    = 4'b1111;
      wdata_c = In_StoreData;
      load_c  = Mem_RData;
    end
  end

  // Next-state / MEM/WB logic; MEM/WB defaults to a bubble
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    valid_d = 1'b0;
    rw_d    = 1'b0;
    m2r_d   = 1'b0;
    mis_d   = 1'b0;
    rdata_d = '0;
    alu_d   = '0;
    rd_d    = '0;
    Stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (memop && !misalign) begin
          Stall   = 1'b1;
          state_d = ST_WAIT;
          req_d   = 1'b1;
          we_d    = In_MemWrite;    // read+write together behaves as a write
          addr_d  = {In_ALUResult[ADDR_W-1:2], 2'b00};
          be_d    = be_c;
          wdata_d = wdata_c;
        end else if (misalign) begin
          valid_d = 1'b1;
          mis_d   = 1'b1;
          alu_d   = In_ALUResult;
          rd_d    = In_RegDstAddress;
        end else begin
          valid_d = In_Valid;
          rw_d    = In_Valid & In_RegWrite;
          m2r_d   = In_Valid & In_MemToReg;
          alu_d   = In_ALUResult;
          rd_d    = In_RegDstAddress;
        end
      end
      ST_WAIT: begin
        Stall = !Mem_Ready;
        if (Mem_Ready) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          rw_d    = In_RegWrite;
          m2r_d   = In_MemToReg;
          alu_d   = In_ALUResult;
          rd_d    = In_RegDstAddress;
          rdata_d = we_q ? '0 : load_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
    end
  end

  assign Mem_Req           = req_q;
  assign Mem_WE            = we_q;
  assign Mem_Addr          = addr_q;
  assign Mem_ByteEn        = be_q;
  assign Mem_WData         = wdata_q;
  assign Out_Valid         = valid_q;
  assign Out_RegWrite      = rw_q;
  assign Out_MemToReg      = m2r_q;
  assign Out_ReadData      = rdata_q;
  assign Out_ALUResult     = alu_q;
  assign Out_RegDstAddress = rd_q;
  assign Out_Misalign      = mis_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  logic        Clk = 1'b0, Rst_n = 1'b0;
  logic        In_Valid, In_RegWrite, In_MemWrite, In_MemRead, In_MemToReg, In_Branch;
  logic        In_Zero, In_SignBit, Mem_Ready;
  logic [31:0] In_ALUResult, In_StoreData, Mem_RData;
  logic [4:0]  In_RegDstAddress;
  logic [1:0]  In_BitSel;
  logic [2:0]  In_BranchLogicOp;
  logic        PCSrc, Stall, Mem_Req, Mem_WE, Out_Valid, Out_RegWrite, Out_MemToReg, Out_Misalign;
  logic [31:0] Mem_Addr, Mem_WData, Out_ReadData, Out_ALUResult;
  logic [3:0]  Mem_ByteEn;
  logic [4:0]  Out_RegDstAddress;

  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        mis;
  } wb_t;
  wb_t sb_q[$];

  always #5 Clk = ~Clk;

  mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_ALUResult(In_ALUResult),
    .In_StoreData(In_StoreData), .In_RegDstAddress(In_RegDstAddress),
    .In_RegWrite(In_RegWrite), .In_MemWrite(In_MemWrite), .In_MemRead(In_MemRead),
    .In_MemToReg(In_MemToReg), .In_Branch(In_Branch), .In_BitSel(In_BitSel),
    .In_BranchLogicOp(In_BranchLogicOp), .In_Zero(In_Zero), .In_SignBit(In_SignBit),
    .PCSrc(PCSrc), .Stall(Stall), .Mem_Req(Mem_Req), .Mem_WE(Mem_WE),
    .Mem_Addr(Mem_Addr), .Mem_ByteEn(Mem_ByteEn), .Mem_WData(Mem_WData),
    .Mem_Ready(Mem_Ready), .Mem_RData(Mem_RData), .Out_Valid(Out_Valid),
    .Out_RegWrite(Out_RegWrite), .Out_MemToReg(Out_MemToReg),
    .Out_ReadData(Out_ReadData), .Out_ALUResult(Out_ALUResult),
    .Out_RegDstAddress(Out_RegDstAddress), .Out_Misalign(Out_Misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // MEM/WB scoreboard: every valid writeback must match the oldest expectation
  always @(negedge Clk) begin
    if (Rst_n && Out_Valid) begin
      if (sb_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
      else begin
        wb_t e;
        e = sb_q.pop_front();
        chk("wb_regwrite", {31'd0, Out_RegWrite}, {31'd0, e.rw});
        chk("wb_memtoreg", {31'd0, Out_MemToReg}, {31'd0, e.m2r});
        chk("wb_readdata", Out_ReadData, e.rdata);
        chk("wb_alures",   Out_ALUResult, e.alu);
        chk("wb_regdst",   {27'd0, Out_RegDstAddress}, {27'd0, e.rd});
        chk("wb_misalign", {31'd0, Out_Misalign}, {31'd0, e.mis});
      end
    end
  end

  function automatic logic [3:0] be_model(input logic [1:0] bs, input logic [1:0] a);
    case (bs)
      2'b01:   return a[1] ? 4'hC : 4'h3;
      2'b10:   return 4'h1 << a;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] rd, input logic [1:0] bs, input logic [1:0] a);
    logic [31:0] s;
    case (bs)
      2'b01: begin s = rd >> (16 * a[1]); return {{16{s[15]}}, s[15:0]}; end
      2'b10: begin s = rd >> (8 * a);     return {{24{s[7]}}, s[7:0]}; end
      default: return rd;
    endcase
  endfunction

  function automatic logic br_model(input logic [2:0] op, input logic z, input logic s);
    case (op)
      3'd0: return z;
      3'd1: return ~z;
      3'd2: return ~s;
      3'd3: return ~s & ~z;
      3'd4: return s | z;
      3'd5: return s;
      default: return 1'b0;
    endcase
  endfunction

  task automatic clear_inputs();
    In_Valid = 0; In_RegWrite = 0; In_MemWrite = 0; In_MemRead = 0; In_MemToReg = 0;
    In_Branch = 0; In_Zero = 0; In_SignBit = 0; In_ALUResult = 0; In_StoreData = 0;
    In_RegDstAddress = 0; In_BitSel = 0; In_BranchLogicOp = 0;
    Mem_Ready = 0; Mem_RData = 32'h5555_5555;
  endtask

  // One memory access with dly not-ready WAIT cycles before Mem_Ready
  task automatic do_memop(input logic [31:0] addr, input logic [31:0] sdata, input logic [1:0] bs,
                          input logic wr, input int dly, input logic [31:0] rdata, input logic [4:0] rd);
    wb_t e;
    In_Valid = 1; In_ALUResult = addr; In_StoreData = sdata; In_BitSel = bs;
    In_MemWrite = wr; In_MemRead = ~wr; In_RegWrite = ~wr; In_MemToReg = ~wr;
    In_RegDstAddress = rd; Mem_Ready = 0;
    #1 chk("stall_issue", {31'd0, Stall}, 32'd1);
    e.rw = ~wr; e.m2r = ~wr; e.alu = addr; e.rd = rd; e.mis = 0;
    e.rdata = wr ? 32'd0 : load_model(rdata, bs, addr[1:0]);
    sb_q.push_back(e);
    @(posedge Clk); #1;
    chk("mem_req",    {31'd0, Mem_Req}, 32'd1);
    chk("mem_we",     {31'd0, Mem_WE}, {31'd0, wr});
    chk("mem_addr",   Mem_Addr, {addr[31:2], 2'b00});
    chk("mem_byteen", {28'd0, Mem_ByteEn}, {28'd0, be_model(bs, addr[1:0])});
    if (wr) chk("mem_wdata", Mem_WData,
                (bs == 2'b01) ? {2{sdata[15:0]}} : (bs == 2'b10) ? {4{sdata[7:0]}} : sdata);
    chk("bubble_valid", {31'd0, Out_Valid}, 32'd0);
    for (int i = 0; i < dly; i++) begin
      chk("stall_wait", {31'd0, Stall}, 32'd1);
      @(posedge Clk); #1;
      chk("req_held",   {31'd0, Mem_Req}, 32'd1);
      chk("addr_held",  Mem_Addr, {addr[31:2], 2'b00});
      chk("bubble_valid", {31'd0, Out_Valid}, 32'd0);
    end
    Mem_Ready = 1; Mem_RData = rdata;
    #1 chk("stall_ready", {31'd0, Stall}, 32'd0);
    @(posedge Clk); #1;
    chk("req_drop", {31'd0, Mem_Req}, 32'd0);
    chk("done_valid", {31'd0, Out_Valid}, 32'd1);
    clear_inputs();
  endtask

  initial begin
    wb_t e;
    clear_inputs();
    #1;
    chk("rst_req",   {31'd0, Mem_Req}, 32'd0);
    chk("rst_valid", {31'd0, Out_Valid}, 32'd0);
    chk("rst_mis",   {31'd0, Out_Misalign}, 32'd0);
    chk("rst_alu",   Out_ALUResult, 32'd0);
    @(negedge Clk); @(negedge Clk); Rst_n = 1;
    @(posedge Clk); #1;

    // ALU pass-through
    In_Valid = 1; In_RegWrite = 1; In_ALUResult = 32'h42; In_RegDstAddress = 5;
    #1 chk("alu_stall", {31'd0, Stall}, 32'd0);
    e.rw = 1; e.m2r = 0; e.rdata = 0; e.alu = 32'h42; e.rd = 5; e.mis = 0;
    sb_q.push_back(e);
    @(posedge Clk); #1;
    chk("alu_valid", {31'd0, Out_Valid}, 32'd1);
    chk("alu_stall2", {31'd0, Stall}, 32'd0);
    clear_inputs();

    // Test-plan accesses, then back-to-back with minimum latency
    do_memop(32'h100, 32'h0, 2'b00, 1'b0, 3, 32'hDEADBEEF, 5'd7);
    do_memop(32'h103, 32'h0, 2'b10, 1'b0, 1, 32'h80123456, 5'd8);
    do_memop(32'h102, 32'h1234ABCD, 2'b01, 1'b1, 0, 32'hFFFF_FFFF, 5'd0);
    do_memop(32'h200, 32'hCAFEF00D, 2'b00, 1'b1, 0, 32'h0, 5'd0);
    do_memop(32'h204, 32'h0, 2'b11, 1'b0, 0, 32'h01234567, 5'd9);

    // Sweep byte and half loads across lane offsets
    for (int k = 0; k < 4; k++) begin
      logic [31:0] rv;
      rv = 32'h80FF_7F01 ^ (32'h11 << (8 * k));
      do_memop(32'h300 + k, 32'h0, 2'b10, 1'b0, k % 2, rv, 5'(10 + k));
      if (k % 2 == 0)
        do_memop(32'h400 + k, 32'h0, 2'b01, 1'b0, 0, rv, 5'(20 + k));
    end
    do_memop(32'h500, 32'h0000_00A5, 2'b10, 1'b1, 1, 32'h0, 5'd0);
    do_memop(32'h503, 32'h0000_00A5, 2'b10, 1'b1, 0, 32'h0, 5'd0);

    // Branch decision across every condition code and flag pair
    for (int op = 0; op < 8; op++)
      for (int f = 0; f < 4; f++) begin
        In_Valid = 1; In_Branch = 1; In_BranchLogicOp = 3'(op);
        In_Zero = f[0]; In_SignBit = f[1]; In_ALUResult = 32'(op * 4 + f);
        #1 chk("pcsrc", {31'd0, PCSrc}, {31'd0, br_model(3'(op), f[0], f[1])});
        e.rw = 0; e.m2r = 0; e.rdata = 0; e.alu = 32'(op * 4 + f); e.rd = 0; e.mis = 0;
        sb_q.push_back(e);
        @(posedge Clk); #1;
      end
    In_Valid = 0; In_BranchLogicOp = 3'd3; In_Zero = 0; In_SignBit = 0;
    #1 chk("pcsrc_invalid", {31'd0, PCSrc}, 32'd0);
    clear_inputs();
    @(posedge Clk); #1;

    // Reset while waiting on memory
    In_Valid = 1; In_MemRead = 1; In_RegWrite = 1; In_ALUResult = 32'h600; In_RegDstAddress = 3;
    @(posedge Clk); #1;
    chk("rst_wait_req", {31'd0, Mem_Req}, 32'd1);
    @(posedge Clk); #1;
    clear_inputs();
    Rst_n = 0;
    #1;
    chk("rstw_req",    {31'd0, Mem_Req}, 32'd0);
    chk("rstw_addr",   Mem_Addr, 32'd0);
    chk("rstw_be",     {28'd0, Mem_ByteEn}, 32'd0);
    chk("rstw_valid",  {31'd0, Out_Valid}, 32'd0);
    @(negedge Clk); Rst_n = 1;
    Mem_Ready = 1; Mem_RData = 32'h7777_7777;
    @(posedge Clk); #1;
    chk("rstw_idle_req",   {31'd0, Mem_Req}, 32'd0);
    chk("rstw_idle_valid", {31'd0, Out_Valid}, 32'd0);
    chk("rstw_idle_stall", {31'd0, Stall}, 32'd0);
    clear_inputs();

`ifdef MEM_ALIGN_CHECK_EN
    In_Valid = 1; In_MemRead = 1; In_RegWrite = 1; In_MemToReg = 1;
    In_ALUResult = 32'h102; In_BitSel = 2'b00; In_RegDstAddress = 4;
    #1 chk("mis_stall", {31'd0, Stall}, 32'd0);
    e.rw = 0; e.m2r = 0; e.rdata = 0; e.alu = 32'h102; e.rd = 4; e.mis = 1;
    sb_q.push_back(e);
    @(posedge Clk); #1;
    chk("mis_req",  {31'd0, Mem_Req}, 32'd0);
    chk("mis_flag", {31'd0, Out_Misalign}, 32'd1);
    clear_inputs();
    @(posedge Clk); #1;
    chk("mis_pulse", {31'd0, Out_Misalign}, 32'd0);
`else
    do_memop(32'h102, 32'h0, 2'b00, 1'b0, 0, 32'h89ABCDEF, 5'd4);
    do_memop(32'h101, 32'h0, 2'b01, 1'b0, 0, 32'h89ABCDEF, 5'd6);
    chk("mis_const", {31'd0, Out_Misalign}, 32'd0);
`endif

    repeat (3) @(posedge Clk);
    #1 chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage that consumes the EX/MEM pipeline register fields: ALU result, store data, destination register, control bits, branch flags.
- Resolves the branch decision.
- Performs byte, half or word loads and stores over a req/ready data-memory handshake, and stalls upstream while an access is in flight.
- Registers results into the MEM/WB pipeline register consumed by writeback.

Parameters:
ADDR_W, 32, data-memory address width (low bits of In_ALUResult)
DATA_W, 32, data width; fixed at 32, not to be overridden

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
In_Valid  in  1  EX/MEM fields hold a live instruction
In_ALUResult  in  32  effective address, or result to pass through
In_StoreData  in  32  rt value for stores
In_RegDstAddress  in  5  writeback register
In_RegWrite, In_MemWrite, In_MemRead, In_MemToReg, In_Branch  in  1 each  control
In_BitSel  in  2  00 word, 01 half, 10 byte, 11 treated as word
In_BranchLogicOp  in  3  branch condition select
In_Zero, In_SignBit  in  1 each  ALU flags
PCSrc  out  1  take branch (combinational)
Stall  out  1  hold upstream stages (combinational)
Mem_Req  out  1  access request
Mem_WE  out  1  1 = write
Mem_Addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
Mem_ByteEn  out  4  lane enables
Mem_WData  out  32  lane-replicated store data
Mem_Ready  in  1  access complete this cycle
Mem_RData  in  32  read word, valid with Mem_Ready
Out_Valid, Out_RegWrite, Out_MemToReg  out  1 each  MEM/WB control
Out_ReadData, Out_ALUResult  out  32 each  MEM/WB data
Out_RegDstAddress  out  5  MEM/WB destination
Out_Misalign  out  1  misaligned access flag (see Optional Feature)

Behaviour:
- Reset (async, Rst_n=0):
  - state=IDLE.
  - Every registered output, including Mem_Req and Out_Misalign, is 0.
  - Reset mid-WAIT drops Mem_Req immediately and abandons the access.
- PCSrc = In_Valid & In_Branch & cond. cond by In_BranchLogicOp:
  - 000 Zero (beq)
  - 001 !Zero (bne)
  - 010 !SignBit (bgez)
  - 011 !SignBit & !Zero (bgtz)
  - 100 SignBit | Zero (blez)
  - 101 SignBit (bltz)
  - 110/111 → 0
- FSM states: IDLE, WAIT.
  - IDLE, memop = In_Valid & (In_MemRead | In_MemWrite):
    - memop=0: next edge loads MEM/WB with inputs. Out_Valid=In_Valid, Out_RegWrite=In_Valid & In_RegWrite, Out_ReadData=0. Latency 1.
    - memop=1: Stall=1 combinationally. Next edge latches Mem_Addr, Mem_WE, Mem_ByteEn, Mem_WData, sets Mem_Req=1, goes to WAIT, and loads MEM/WB with a bubble (Out_Valid=0, Out_RegWrite=0).
    - MemRead and MemWrite both set: treated as write.
  - WAIT:
    - Mem_Req and all Mem_* outputs held stable.
    - Stall = !Mem_Ready. Upstream keeps inputs stable while Stall=1.
    - While Mem_Ready=0, MEM/WB receives bubbles.
    - Edge with Mem_Ready=1: Mem_Req→0, state→IDLE. MEM/WB gets Out_Valid=1, RegWrite/MemToReg/RegDst/ALUResult from the inputs, and Out_ReadData = extracted load (0 for stores).
    - Minimum memop latency: 2 edges when Mem_Ready is already high in the first WAIT cycle.
  - A new memop arriving in the IDLE cycle right after completion is issued back-to-back; no dead cycle.
- Byte lanes (little-endian, a = addr[1:0]):
  - word: ByteEn 1111.
  - half: a[1]=0 → 0011, a[1]=1 → 1100.
  - byte: 0001 << a.
- Store data:
  - half: WData={2{d[15:0]}}.
  - byte: WData={4{d[7:0]}}.
- Loads:
  - Lane selected by the same address bits.
  - Sign-extended to 32 bits.
- Mem_RData is ignored unless Mem_Ready=1 in WAIT. Mem_Ready in IDLE is ignored.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined:
  - In IDLE, a memop is misaligned if word with a≠00, or half with a[0]=1.
  - A misaligned memop issues no Mem_Req and no stall.
  - Next edge: Out_Misalign=1 for one cycle, Out_Valid=1, Out_RegWrite=0 (no writeback).
- Undefined:
  - Word ignores a; half ignores a[0].
  - Out_Misalign is constant 0.

Test Plan:
- ALU op: In_Valid=1, RegWrite=1, ALUResult=0x0000_0042, RegDst=5, no memop → next edge Out_Valid=1, Out_ALUResult=0x42, Out_RegDstAddress=5, Out_RegWrite=1, Stall never high.
- Word load, memory ready after 3 WAIT cycles: addr 0x100 → Mem_Req held 3 cycles with Mem_Addr=0x100, ByteEn=1111, Stall high for 4 cycles; RData=0xDEADBEEF → Out_ReadData=0xDEADBEEF; Out_Valid=0 on the bubble edges.
- Byte load at 0x103, RData=0x80xxxxxx → ByteEn 1000, Out_ReadData=0xFFFFFF80. Half store at 0x102, data 0x1234ABCD → ByteEn 1100, WData=0xABCDABCD, Out_RegWrite=0.
- Branch: BranchLogicOp=011, Zero=0, SignBit=0, Branch=1 → PCSrc=1. Same with Zero=1 → PCSrc=0. Codes 110 and 111 → PCSrc=0.
- Rst_n pulled low during WAIT → Mem_Req=0 and all outputs 0 immediately. After release: state IDLE, no stale writeback.
- With MEM_ALIGN_CHECK_EN: word load at 0x102 → no Mem_Req, Out_Misalign pulses 1 cycle, Out_RegWrite=0. Without it: access issued at Mem_Addr 0x100.
